nmux_arb: RTL and testbench

- Parametrised successor to the team's N-bit 2-to-1 mux.
- Selects one of M requesting channels, each W bits wide, and registers the winner into a one-entry output stage with a valid/ready handshake.
- Target use: sharing a single-ported resource between pipeline stages, e.g. IF and MEM contending for unified memory, or multiple writeback sources.
- Arbitration is fixed-priority or round-robin, chosen by parameter.

---
 rtl/nmux_arb_if.sv | 52 +++++
 rtl/nmux_arb.sv | 137 +++++++++++++
 tb/tb_nmux_arb.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmux_arb_if.sv
// nmux_arb_if: bundle of the arbiter's request and output handshake signals.
//
// Parameters
//   W  data width per channel in bits
//   M  number of request channels
//
// Signals (directions as seen by the arbiter, i.e. the slave modport)
//   req_valid_i  [M]    per-channel request valid
//   req_data_i   [M*W]  packed channel data, channel k at [k*W +: W]
//   req_ready_o  [M]    per-channel accept, at most one bit high
//   out_valid_o         output register holds valid data
//   out_data_o   [W]    registered selected data
//   out_sel_o    [SW]   index of the channel that produced out_data_o
//   out_ready_i         downstream accepts out_data_o this cycle
//
// Modports
//   slave   the arbiter itself
//   master  the environment driving requests and consuming the output
interface nmux_arb_if #(
    parameter int unsigned W = 32,
    parameter int unsigned M = 2
);
    localparam int unsigned SW = $clog2(M);

    logic [M-1:0]   req_valid_i;
    logic [M*W-1:0] req_data_i;
    logic [M-1:0]   req_ready_o;
    logic           out_valid_o;
    logic [W-1:0]   out_data_o;
    logic [SW-1:0]  out_sel_o;
    logic           out_ready_i;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  out_ready_i,
        output req_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_sel_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output out_ready_i,
        input  req_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_sel_o
    );
endinterface

// File: rtl/nmux_arb.sv
// nmux_arb: M-channel arbiter with a one-entry registered output stage.
//
// Picks one of M requesting channels (fixed priority or round-robin) and
// registers its W-bit data into an output register with a valid/ready
// handshake. Intended for sharing a single-ported resource between pipeline
// stages (e.g. fetch and memory stage on a unified memory port).
//
// Parameters
//   W     data width per channel in bits
//   M     number of input channels (M >= 2)
//   MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports
//   clk_i  clock, all state updates on the rising edge
//   rst_i  asynchronous active-high reset
//   bus    nmux_arb_if.slave: request valid/data/ready per channel and the
//          registered output valid/data/sel with out_ready_i backpressure
module nmux_arb #(
    parameter int unsigned W    = 32,
    parameter int unsigned M    = 2,
    parameter int unsigned MODE = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    nmux_arb_if.slave  bus
);
    localparam int unsigned SW = $clog2(M);

    // Round-robin pointer: channel with highest priority for the next grant.
    logic [SW-1:0] ptr_q, ptr_d;

    // Output stage.
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;

    // Arbitration results.
    logic          gnt_found;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_data;
    logic          can_load;
    logic [M-1:0]  req_ready;
    logic          xfer;

    // Output register may be refilled in the same cycle it drains.
    assign can_load = !out_valid_q || bus.out_ready_i;

    // Grant scan: first valid channel walking upward from the base index,
    // wrapping M-1 -> 0. Fixed priority is the same scan from base 0.
    always_comb begin
        logic [SW:0]   idx;
        logic [SW-1:0] base;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        base      = (MODE == 1) ? ptr_q : '0;
        for (int unsigned k = 0; k < M; k++) begin
            // One extra bit so base + k cannot overflow before the wrap.
            idx = {1'b0, base} + (SW+1)'(k);
            if (idx >= (SW+1)'(M)) begin
                idx = idx - (SW+1)'(M);
            end
            if (!gnt_found && bus.req_valid_i[idx[SW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[SW-1:0];
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (gnt_idx == SW'(k)) begin
                gnt_data = bus.req_data_i[k*W +: W];
            end
        end
    end

    // Accept goes to the granted channel only; held low throughout reset.
    always_comb begin
        req_ready = '0;
        if (!rst_i && can_load && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // req_ready is only ever set for a valid channel, so any ready bit is a transfer.
    assign xfer = |req_ready;

    // Next-state for the output stage. Draining leaves data/sel untouched.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_sel_d   = gnt_idx;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer moves just past the winner, so a continuously asserted channel
    // is served within M transfers.
    always_comb begin
        ptr_d = ptr_q;
        if (MODE == 1 && xfer) begin
            if (gnt_idx == SW'(M - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_nmux_arb.sv
// tb_nmux_arb: directed self-checking bench for nmux_arb.
// Three instances share clock and reset:
//   dut_a  M=2, MODE 0 (single channel, backpressure)
//   dut_b  M=4, MODE 0 (fixed priority)
//   dut_c  M=4, MODE 1 (round-robin, async reset mid-stall)
module tb_nmux_arb;
    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    nmux_arb_if #(.W(32), .M(2)) if_a ();
    nmux_arb_if #(.W(32), .M(4)) if_b ();
    nmux_arb_if #(.W(32), .M(4)) if_c ();

    nmux_arb #(.W(32), .M(2), .MODE(0)) dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
    nmux_arb #(.W(32), .M(4), .MODE(0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
    nmux_arb #(.W(32), .M(4), .MODE(1)) dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; registered outputs are stable after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // Requests during reset must not be accepted.
        if_a.req_valid_i = 2'b11;
        if_a.out_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (if_a.req_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_ready_forced: got %b expected 00", if_a.req_ready_o);
            end
            n_checks++;
            if (if_c.out_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid_c: got %b expected 0", if_c.out_valid_o);
            end
            tick();
        end
        if_a.req_valid_i = 2'b00;
        if_a.out_ready_i = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (if_a.out_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid cyc%0d: got %b expected 0", i, if_a.out_valid_o);
            end
            n_checks++;
            if (if_a.out_data_o !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_data cyc%0d: got %h expected 0", i, if_a.out_data_o);
            end
            n_checks++;
            if (if_a.req_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_ready cyc%0d: got %b expected 00", i, if_a.req_ready_o);
            end
            n_checks++;
            if (if_a.out_sel_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_sel cyc%0d: got %h expected 0", i, if_a.out_sel_o);
            end
            tick();
        end
    endtask

    task automatic test_single();
        if_a.req_data_i  = {32'hDEADBEEF, 32'h11111111};
        if_a.req_valid_i = 2'b10;
        if_a.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (if_a.req_ready_o !== 2'b10) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 10", if_a.req_ready_o);
        end
        tick();
        if_a.req_valid_i = 2'b00;
        n_checks++;
        if (if_a.out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_valid: got %b expected 1", if_a.out_valid_o);
        end
        n_checks++;
        if (if_a.out_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_data: got %h expected deadbeef", if_a.out_data_o);
        end
        n_checks++;
        if (if_a.out_sel_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_sel: got %h expected 1", if_a.out_sel_o);
        end
        tick();
        // Drain: valid drops, data and sel keep their last values.
        n_checks++;
        if (if_a.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_valid: got %b expected 0", if_a.out_valid_o);
        end
        n_checks++;
        if (if_a.out_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL drain_data_kept: got %h expected deadbeef", if_a.out_data_o);
        end
        n_checks++;
        if (if_a.out_sel_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_sel_kept: got %h expected 1", if_a.out_sel_o);
        end
        if_a.out_ready_i = 1'b0;
    endtask

    task automatic test_fixed_priority();
        if_b.req_data_i  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
        if_b.req_valid_i = 4'b1010;
        if_b.out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (if_b.req_ready_o !== 4'b0010) begin
                n_fail++;
                $display("FAIL fixed_ready beat%0d: got %b expected 0010", i, if_b.req_ready_o);
            end
            tick();
            n_checks++;
            if (if_b.out_valid_o !== 1'b1 || if_b.out_sel_o !== 2'd1 ||
                if_b.out_data_o !== 32'h1111_0001) begin
                n_fail++;
                $display("FAIL fixed_beat%0d: got v=%b sel=%0d data=%h expected v=1 sel=1 data=11110001",
                         i, if_b.out_valid_o, if_b.out_sel_o, if_b.out_data_o);
            end
        end
        if_b.req_valid_i = 4'b0000;
        tick();
        n_checks++;
        if (if_b.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_drain: got %b expected 0", if_b.out_valid_o);
        end
        if_b.out_ready_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [1:0] exp_sel;
        if_c.req_data_i  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        if_c.req_valid_i = 4'b1111;
        if_c.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (if_c.req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_first_ready: got %b expected 0001", if_c.req_ready_o);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_sel = 2'(i % 4);
            n_checks++;
            if (if_c.out_valid_o !== 1'b1 || if_c.out_sel_o !== exp_sel ||
                if_c.out_data_o !== {30'h3037_8000, exp_sel}) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                         i, if_c.out_valid_o, if_c.out_sel_o, if_c.out_data_o, exp_sel,
                         {30'h3037_8000, exp_sel});
            end
            exp_ready = 4'b0001 << ((i + 1) % 4);
            n_checks++;
            if (if_c.req_ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL rr_ready%0d: got %b expected %b", i, if_c.req_ready_o, exp_ready);
            end
        end
        // Leaves the pointer at 2.
        if_c.req_valid_i = 4'b0000;
        tick();
        n_checks++;
        if (if_c.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain: got %b expected 0", if_c.out_valid_o);
        end
        if_c.out_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        if_a.req_data_i  = {32'h0, 32'h12345678};
        if_a.req_valid_i = 2'b01;
        if_a.out_ready_i = 1'b1;
        tick();
        if_a.req_data_i  = {32'h0, 32'hA5A5A5A5};
        if_a.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (if_a.out_data_o !== 32'h12345678 || if_a.out_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: got v=%b data=%h expected v=1 data=12345678",
                         i, if_a.out_valid_o, if_a.out_data_o);
            end
            n_checks++;
            if (if_a.req_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_ready cyc%0d: got %b expected 00", i, if_a.req_ready_o);
            end
            tick();
        end
        if_a.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (if_a.req_ready_o !== 2'b01) begin
            n_fail++;
            $display("FAIL release_ready: got %b expected 01", if_a.req_ready_o);
        end
        tick();
        if_a.req_valid_i = 2'b00;
        n_checks++;
        if (if_a.out_data_o !== 32'hA5A5A5A5 || if_a.out_valid_o !== 1'b1 ||
            if_a.out_sel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL release_data: got v=%b sel=%0d data=%h expected v=1 sel=0 data=a5a5a5a5",
                     if_a.out_valid_o, if_a.out_sel_o, if_a.out_data_o);
        end
        tick();
        if_a.out_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        // Pointer is 2 from the round-robin run; load ch2 and stall.
        if_c.req_valid_i = 4'b1111;
        if_c.out_ready_i = 1'b0;
        tick();
        n_checks++;
        if (if_c.out_valid_o !== 1'b1 || if_c.out_sel_o !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got v=%b sel=%0d expected v=1 sel=2",
                     if_c.out_valid_o, if_c.out_sel_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (if_c.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_valid_drop: got %b expected 0", if_c.out_valid_o);
        end
        n_checks++;
        if (if_c.out_data_o !== 32'h0 || if_c.req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_clear: got data=%h ready=%b expected data=0 ready=0000",
                     if_c.out_data_o, if_c.req_ready_o);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (if_c.req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b expected 0001", if_c.req_ready_o);
        end
        tick();
        n_checks++;
        if (if_c.out_valid_o !== 1'b1 || if_c.out_sel_o !== 2'd0 ||
            if_c.out_data_o !== 32'hC0DE_0000) begin
            n_fail++;
            $display("FAIL post_reset_load: got v=%b sel=%0d data=%h expected v=1 sel=0 data=c0de0000",
                     if_c.out_valid_o, if_c.out_sel_o, if_c.out_data_o);
        end
        if_c.req_valid_i = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        if_a.req_valid_i = '0;
        if_a.req_data_i  = '0;
        if_a.out_ready_i = 1'b0;
        if_b.req_valid_i = '0;
        if_b.req_data_i  = '0;
        if_b.out_ready_i = 1'b0;
        if_c.req_valid_i = '0;
        if_c.req_data_i  = '0;
        if_c.out_ready_i = 1'b0;

        test_reset();
        test_single();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
